// File: rtl/gpio_pkg.sv
// Shared register map and APB FSM encoding for the GPIO bank.
// Addresses above IRQ_STAT are reserved and answer with pslverr.
package gpio_pkg;

  localparam int ADDR_DIR      = 0;
  localparam int ADDR_OUT      = 1;
  localparam int ADDR_IN       = 2;
  localparam int ADDR_IRQ_EN   = 3;
  localparam int ADDR_IRQ_TYPE = 4;
  localparam int ADDR_IRQ_STAT = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchronizer plus one-cycle-delayed copy for edge detection.
// Edges are masked until the delayed copy holds a real sample, so pins high at reset never flag.
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             sclk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [2:0]       arm;

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
      arm  <= '0;
    end else begin
      meta <= pin_in;
      sync <= meta;
      prev <= sync;
      arm  <= {arm[1:0], 1'b1};
    end
  end

  assign pin_sync = sync;
  assign rise     = arm[2] ? (sync & ~prev) : '0;
  assign fall     = arm[2] ? (~sync & prev) : '0;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: DIR/OUT/IN/IRQ registers, completion WAIT_STATES+1 cycles after setup.
// Master holds the access phase until pready; dropping psel early aborts with no register change.
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int WAIT_STATES = 1
) (
  input  logic                  b_pclk,
  input  logic                  b_presetn,
  input  logic                  b_psel,
  input  logic                  b_penable,
  input  logic                  b_pwrite,
  input  logic [ADDR_WIDTH-1:0] b_paddr,
  input  logic [DATA_WIDTH-1:0] b_pwdata,
  output logic [DATA_WIDTH-1:0] b_prdata,
  output logic                  b_pready,
  output logic                  b_pslverr,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  apb_state_t            state, state_nxt;
  logic [2:0]            wait_cnt;
  logic                  setup;
  logic                  addr_rsvd;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] dir_q, out_q, en_q, type_q, stat_q;
  logic [DATA_WIDTH-1:0] pin_sync, rise, fall;
  logic [DATA_WIDTH-1:0] edge_set, stat_clr;
  logic                  irq_q;

  assign setup = b_psel & ~b_penable;

  always_ff @(posedge b_pclk or negedge b_presetn) begin
    if (!b_presetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (setup)
        wait_cnt <= '0;
      else if (state == ACCESS && !b_pready)
        wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!b_psel || b_pready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign b_pready = (state == ACCESS) & b_psel & b_penable & (wait_cnt == WAIT_CNT);

  always_comb begin
    rd_val    = '0;
    addr_rsvd = 1'b0;
    case (b_paddr)
      ADDR_WIDTH'(ADDR_DIR):      rd_val = dir_q;
      ADDR_WIDTH'(ADDR_OUT):      rd_val = out_q;
      ADDR_WIDTH'(ADDR_IN):       rd_val = pin_sync;
      ADDR_WIDTH'(ADDR_IRQ_EN):   rd_val = en_q;
      ADDR_WIDTH'(ADDR_IRQ_TYPE): rd_val = type_q;
      ADDR_WIDTH'(ADDR_IRQ_STAT): rd_val = stat_q;
      default:                    addr_rsvd = 1'b1;
    endcase
  end

  assign wr_fire   = b_psel & b_penable & b_pwrite & b_pready & ~addr_rsvd;
  assign b_prdata  = (b_pready & ~b_pwrite) ? rd_val : '0;
  assign b_pslverr = b_pready & addr_rsvd;

  gpio_sync_edge #(
    .WIDTH (DATA_WIDTH)
  ) u_sync_edge (
    .sclk     (b_pclk),
    .resetn   (b_presetn),
    .pin_in   (gpio_in),
    .pin_sync (pin_sync),
    .rise     (rise),
    .fall     (fall)
  );

  // IRQ_TYPE bit 0 selects rising, 1 selects falling; an edge beats a same-cycle W1C.
  assign edge_set = (rise & ~type_q) | (fall & type_q);
  assign stat_clr = (wr_fire && b_paddr == ADDR_WIDTH'(ADDR_IRQ_STAT)) ? b_pwdata : '0;

  always_ff @(posedge b_pclk or negedge b_presetn) begin
    if (!b_presetn) begin
      dir_q  <= '0;
      out_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_fire && b_paddr == ADDR_WIDTH'(ADDR_DIR))      dir_q  <= b_pwdata;
      if (wr_fire && b_paddr == ADDR_WIDTH'(ADDR_OUT))      out_q  <= b_pwdata;
      if (wr_fire && b_paddr == ADDR_WIDTH'(ADDR_IRQ_EN))   en_q   <= b_pwdata;
      if (wr_fire && b_paddr == ADDR_WIDTH'(ADDR_IRQ_TYPE)) type_q <= b_pwdata;
      stat_q <= (stat_q & ~stat_clr) | edge_set;
      irq_q  <= |(stat_q & en_q);
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank (defaults: 8-bit data, 3-bit address, one wait state).
module tb_apb_gpio_bank;

  logic       b_pclk    = 1'b0;
  logic       b_presetn = 1'b0;
  logic       b_psel    = 1'b0;
  logic       b_penable = 1'b0;
  logic       b_pwrite  = 1'b0;
  logic [2:0] b_paddr   = '0;
  logic [7:0] b_pwdata  = '0;
  logic [7:0] gpio_in   = '0;
  logic [7:0] b_prdata;
  logic       b_pready;
  logic       b_pslverr;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_bank #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (3),
    .WAIT_STATES (1)
  ) dut (
    .b_pclk    (b_pclk),
    .b_presetn (b_presetn),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_pwrite  (b_pwrite),
    .b_paddr   (b_paddr),
    .b_pwdata  (b_pwdata),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready),
    .b_pslverr (b_pslverr),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  always #5 b_pclk = ~b_pclk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  // One full transfer; optionally changes gpio_in in the setup cycle so an edge lands on the commit edge.
  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                          input logic chg, input logic [7:0] new_in,
                          output logic [7:0] rdata, output logic err, output int acc);
    @(posedge b_pclk); #1;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr; b_paddr = addr; b_pwdata = wdata;
    if (chg) gpio_in = new_in;
    @(posedge b_pclk); #1;
    b_penable = 1'b1;
    acc = 0; rdata = '0; err = 1'b0;
    forever begin
      acc++;
      @(negedge b_pclk);
      if (b_pready) begin
        rdata = b_prdata;
        err   = b_pslverr;
        break;
      end
      if (acc >= 16) begin
        chk("pready_timeout", 8'(b_pready), 8'h01);
        break;
      end
      @(posedge b_pclk); #1;
    end
    @(posedge b_pclk); #1;
    b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    logic [7:0] d;
    logic       e;
    int         a;
    apb_xfer(1'b1, addr, data, 1'b0, 8'h00, d, e, a);
    chk("wr_slverr", 8'(e), 8'h00);
  endtask

  task automatic rd(input logic [2:0] addr, output logic [7:0] data);
    logic e;
    int   a;
    apb_xfer(1'b0, addr, 8'h00, 1'b0, 8'h00, data, e, a);
  endtask

  initial begin
    logic [7:0] rv;
    logic       re;
    int         ra;

    // Reset state
    repeat (2) @(posedge b_pclk);
    @(negedge b_pclk);
    chk("rst_pready", 8'(b_pready), 8'h00);
    chk("rst_pslverr", 8'(b_pslverr), 8'h00);
    chk("rst_prdata", b_prdata, 8'h00);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_gpio_oe", gpio_oe, 8'h00);
    chk("rst_irq", 8'(irq), 8'h00);
    @(posedge b_pclk); #1;
    b_presetn = 1'b1;
    repeat (4) @(posedge b_pclk);

    // DIR write: pready on 2nd access cycle, gpio_oe follows on commit
    apb_xfer(1'b1, 3'd0, 8'hA5, 1'b0, 8'h00, rv, re, ra);
    chk("dir_wr_acc_cycles", 8'(ra), 8'h02);
    chk("dir_wr_slverr", 8'(re), 8'h00);
    chk("gpio_oe_after_dir", gpio_oe, 8'hA5);

    wr(3'd1, 8'h3C);
    chk("gpio_out_after_out", gpio_out, 8'h3C);
    apb_xfer(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, rv, re, ra);
    chk("rd_dir", rv, 8'hA5);
    chk("rd_dir_acc_cycles", 8'(ra), 8'h02);
    rd(3'd1, rv);
    chk("rd_out", rv, 8'h3C);

    // Write to IN is ignored without error
    wr(3'd2, 8'hFF);
    rd(3'd2, rv);
    chk("rd_in_zero", rv, 8'h00);

    // Rising edges on bits 0..3, only bit 0 enabled
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h01);
    gpio_in = 8'h0F;
    repeat (3) @(posedge b_pclk);
    @(negedge b_pclk);
    chk("irq_before_stat_seen", 8'(irq), 8'h00);
    @(negedge b_pclk);
    chk("irq_one_after_stat", 8'(irq), 8'h01);
    rd(3'd5, rv);
    chk("stat_rise_0f", rv, 8'h0F);
    rd(3'd2, rv);
    chk("rd_in_0f", rv, 8'h0F);

    // Mixed types: bit1 falling, bit4 rising
    wr(3'd4, 8'h02);
    wr(3'd5, 8'hFF);
    rd(3'd5, rv);
    chk("stat_w1c_all", rv, 8'h00);
    gpio_in = 8'h1D;
    repeat (5) @(posedge b_pclk);
    rd(3'd5, rv);
    chk("stat_fall_rise_12", rv, 8'h12);
    chk("irq_masked", 8'(irq), 8'h00);
    wr(3'd3, 8'h10);
    @(negedge b_pclk);
    chk("irq_en_lag", 8'(irq), 8'h00);
    @(negedge b_pclk);
    chk("irq_en_set", 8'(irq), 8'h01);

    // Partial W1C, then W1C racing a new rising edge on bit 0
    wr(3'd5, 8'h02);
    rd(3'd5, rv);
    chk("stat_partial_w1c", rv, 8'h10);
    wr(3'd5, 8'h10);
    gpio_in = 8'h1C;
    repeat (4) @(posedge b_pclk);
    rd(3'd5, rv);
    chk("stat_clear_before_race", rv, 8'h00);
    apb_xfer(1'b1, 3'd5, 8'h01, 1'b1, 8'h1D, rv, re, ra);
    rd(3'd5, rv);
    chk("stat_edge_beats_w1c", rv, 8'h01);
    wr(3'd5, 8'h01);
    rd(3'd5, rv);
    chk("stat_w1c_no_edge", rv, 8'h00);

    // Reserved addresses
    apb_xfer(1'b0, 3'd6, 8'h00, 1'b0, 8'h00, rv, re, ra);
    chk("rsvd_rd_data", rv, 8'h00);
    chk("rsvd_rd_slverr", 8'(re), 8'h01);
    chk("rsvd_rd_acc_cycles", 8'(ra), 8'h02);
    apb_xfer(1'b1, 3'd7, 8'hFF, 1'b0, 8'h00, rv, re, ra);
    chk("rsvd_wr_slverr", 8'(re), 8'h01);
    rd(3'd0, rv);
    chk("rsvd_dir_unchanged", rv, 8'hA5);
    rd(3'd1, rv);
    chk("rsvd_out_unchanged", rv, 8'h3C);
    rd(3'd4, rv);
    chk("rsvd_type_unchanged", rv, 8'h02);

    // Abort: drop psel mid-wait on a write to OUT
    @(posedge b_pclk); #1;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 3'd1; b_pwdata = 8'h99;
    @(posedge b_pclk); #1;
    b_penable = 1'b1;
    @(negedge b_pclk);
    chk("abort_wait_pready", 8'(b_pready), 8'h00);
    @(posedge b_pclk); #1;
    b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
    @(negedge b_pclk);
    chk("abort_pready_low", 8'(b_pready), 8'h00);
    repeat (2) @(posedge b_pclk);
    chk("abort_gpio_out", gpio_out, 8'h3C);
    apb_xfer(1'b0, 3'd1, 8'h00, 1'b0, 8'h00, rv, re, ra);
    chk("abort_then_rd_out", rv, 8'h3C);
    chk("abort_then_acc_cycles", 8'(ra), 8'h02);

    // Reset asserted while a write is completing
    @(posedge b_pclk); #1;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 3'd1; b_pwdata = 8'h77;
    @(posedge b_pclk); #1;
    b_penable = 1'b1;
    @(posedge b_pclk); #1;
    @(negedge b_pclk);
    chk("midwr_pready_before_rst", 8'(b_pready), 8'h01);
    #1 b_presetn = 1'b0;
    #1;
    chk("async_rst_pready", 8'(b_pready), 8'h00);
    chk("async_rst_pslverr", 8'(b_pslverr), 8'h00);
    chk("async_rst_prdata", b_prdata, 8'h00);
    chk("async_rst_gpio_out", gpio_out, 8'h00);
    chk("async_rst_gpio_oe", gpio_oe, 8'h00);
    chk("async_rst_irq", 8'(irq), 8'h00);
    @(posedge b_pclk); #1;
    b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
    @(posedge b_pclk); #1;
    b_presetn = 1'b1;
    repeat (6) @(posedge b_pclk);
    rd(3'd1, rv);
    chk("post_rst_out", rv, 8'h00);
    rd(3'd0, rv);
    chk("post_rst_dir", rv, 8'h00);
    rd(3'd5, rv);
    chk("post_rst_no_false_edge", rv, 8'h00);
    rd(3'd2, rv);
    chk("post_rst_in", rv, 8'h1D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
